// File: rtl/nestloop_pkg.sv
// Shared state encoding and sizing helpers for the nested loop sequencer.
package nestloop_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Outstanding-call counter must be able to hold MAX_OUTSTANDING itself.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/nestloop_dim.sv
// One loop dimension: trip counter plus index register that steps by a signed
// stride and reloads its start index when it wraps.
module nestloop_dim
    import nestloop_pkg::*;
#(
    parameter int LEN_DWIDTH = 32,
    parameter int INC_DWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LEN_DWIDTH-1:0] init,
    input  logic [LEN_DWIDTH-1:0] len,
    input  logic [INC_DWIDTH-1:0] inc,
    input  logic                  step_in,
    output logic                  carry_out,
    output logic                  carry_next,
    output logic [LEN_DWIDTH-1:0] idx
);

    localparam logic [LEN_DWIDTH-1:0] ONE = LEN_DWIDTH'(1);

    logic [LEN_DWIDTH-1:0] init_q, len_q, count;
    logic [LEN_DWIDTH-1:0] count_n, idx_n, len_n, inc_ext;
    logic [INC_DWIDTH-1:0] inc_q;

    assign inc_ext   = LEN_DWIDTH'($signed(inc_q));
    assign carry_out = (count == len_q - ONE);

    // carry_next is what carry_out will be after this edge; the top uses it
    // to register ap_last alongside the index it belongs to.
    always_comb begin
        count_n = count;
        idx_n   = idx;
        len_n   = len_q;
        if (load) begin
            count_n = '0;
            idx_n   = init;
            len_n   = len;
        end else if (step_in) begin
            if (carry_out) begin
                count_n = '0;
                idx_n   = init_q;
            end else begin
                count_n = count + ONE;
                idx_n   = idx + inc_ext;
            end
        end
        carry_next = (count_n == len_n - ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q <= '0;
            len_q  <= '0;
            inc_q  <= '0;
            count  <= '0;
            idx    <= '0;
        end else begin
            count <= count_n;
            idx   <= idx_n;
            if (load) begin
                init_q <= init;
                len_q  <= len;
                inc_q  <= inc;
            end
        end
    end

endmodule

// File: rtl/nestloop.sv
// Nested loop sequencer: walks NUM_DIMS index dimensions and drives one HLS
// function through its ap_* handshake, with bounded pipelined issue.
module nestloop
    import nestloop_pkg::*;
#(
    parameter int NUM_DIMS        = 2,
    parameter int LEN_DWIDTH      = 32,
    parameter int INC_DWIDTH      = 16,
    parameter int ENABLE_PIPELINE = 1,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_start,
    input  logic                           cmd_abort,
    input  logic [NUM_DIMS*LEN_DWIDTH-1:0] cmd_loop_init_i,
    input  logic [NUM_DIMS*LEN_DWIDTH-1:0] cmd_loop_len_i,
    input  logic [NUM_DIMS*INC_DWIDTH-1:0] cmd_loop_inc_i,
    input  logic                           cmd_break_en_i,
    output logic                           cmd_loop_idle_o,
    output logic                           cmd_loop_done_o,
    output logic                           cmd_loop_break_o,
    output logic [LEN_DWIDTH-1:0]          cmd_loop_iter_o,
    output logic                           ap_start,
    input  logic                           ap_ready,
    input  logic                           ap_done,
    input  logic                           ap_idle,
    input  logic                           ap_return,
    output logic [NUM_DIMS*LEN_DWIDTH-1:0] ap_idx,
    output logic                           ap_last,
    output logic [3:0]                     dbg_status
);

    localparam int OW = cnt_width(MAX_OUTSTANDING);
    localparam logic [OW-1:0] MAX_EFF = OW'(ENABLE_PIPELINE != 0 ? MAX_OUTSTANDING : 1);

    state_t                state, state_n;
    logic [OW-1:0]         outstanding, out_next;
    logic [LEN_DWIDTH-1:0] iter;
    logic                  start_acc, issue, done_v, dec, brk_evt, any_zero, start_n, brk_q;
    logic [NUM_DIMS-1:0]   chain, carry, carry_n;

    // Handshake: a call is accepted on the cycle ap_start & ap_ready are both
    // high; ap_start and ap_idx stay stable until then (or until a break/abort
    // withdraws the request). ap_done marks one earlier call as finished.
    assign start_acc = (state == S_IDLE) && cmd_start;
    assign issue     = ap_start && ap_ready;
    assign done_v    = ap_done && (state != S_IDLE);
    assign dec       = done_v && ((outstanding != '0) || issue);
    assign out_next  = outstanding + OW'(issue) - OW'(dec);
    assign brk_evt   = ((state == S_ISSUE) || (state == S_WAIT)) &&
                       (cmd_abort || (cmd_break_en_i && ap_done && ap_return));

    always_comb begin
        any_zero = 1'b0;
        for (int k = 0; k < NUM_DIMS; k++) begin
            if (cmd_loop_len_i[k*LEN_DWIDTH +: LEN_DWIDTH] == '0) any_zero = 1'b1;
        end
    end

    assign chain[0] = issue;

    for (genvar k = 0; k < NUM_DIMS; k++) begin : g_dim
        nestloop_dim #(
            .LEN_DWIDTH (LEN_DWIDTH),
            .INC_DWIDTH (INC_DWIDTH)
        ) u_dim (
            .clk        (clk),
            .rst        (rst),
            .load       (start_acc),
            .init       (cmd_loop_init_i[k*LEN_DWIDTH +: LEN_DWIDTH]),
            .len        (cmd_loop_len_i[k*LEN_DWIDTH +: LEN_DWIDTH]),
            .inc        (cmd_loop_inc_i[k*INC_DWIDTH +: INC_DWIDTH]),
            .step_in    (chain[k]),
            .carry_out  (carry[k]),
            .carry_next (carry_n[k]),
            .idx        (ap_idx[k*LEN_DWIDTH +: LEN_DWIDTH])
        );
        if (k < NUM_DIMS - 1) begin : g_carry
            assign chain[k+1] = chain[k] & carry[k];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (cmd_start) state_n = any_zero ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (brk_evt || (issue && ap_last)) state_n = (out_next == '0) ? S_DONE : S_DRAIN;
                else if (issue && ENABLE_PIPELINE == 0) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (brk_evt) state_n = (out_next == '0) ? S_DONE : S_DRAIN;
                else if (done_v) state_n = S_ISSUE;
            end
            S_DRAIN: if (out_next == '0) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        start_n = (state_n == S_ISSUE) && (out_next < MAX_EFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            outstanding <= '0;
            iter        <= '0;
            brk_q       <= 1'b0;
            ap_start    <= 1'b0;
            ap_last     <= 1'b0;
        end else begin
            state    <= state_n;
            ap_start <= start_n;
            ap_last  <= start_n && (&carry_n);
            if (start_acc) begin
                outstanding <= '0;
                iter        <= '0;
                brk_q       <= 1'b0;
            end else begin
                outstanding <= out_next;
                if (done_v) iter <= iter + LEN_DWIDTH'(1);
                if (brk_evt) brk_q <= 1'b1;
            end
        end
    end

    assign cmd_loop_idle_o  = (state == S_IDLE);
    assign cmd_loop_done_o  = (state == S_DONE);
    assign cmd_loop_break_o = (state == S_DONE) && brk_q;
    assign cmd_loop_iter_o  = iter;
    assign dbg_status       = {ap_idle, state};

endmodule

// File: tb/tb_nestloop.sv
// Directed bench for nestloop: three instances (pipelined, MAX_OUTSTANDING=2,
// one call in flight) driven by a latency-based HLS responder.
module tb_nestloop;

  localparam int ND = 2;
  localparam int LW = 32;
  localparam int IW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       start, abort, ready, done, ret;
  logic [2:0]       idle_o, done_o, brk_o, ap_start, ap_last;
  logic [ND*LW-1:0] init, len;
  logic [ND*IW-1:0] inc;
  logic             brk_en, ap_idle_in;
  logic [LW-1:0]    iter_o [3];
  logic [ND*LW-1:0] idx_o [3];
  logic [3:0]       dbg [3];

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q [$];

  nestloop u_pipe (
    .clk(clk), .rst(rst), .cmd_start(start[0]), .cmd_abort(abort[0]),
    .cmd_loop_init_i(init), .cmd_loop_len_i(len), .cmd_loop_inc_i(inc),
    .cmd_break_en_i(brk_en), .cmd_loop_idle_o(idle_o[0]), .cmd_loop_done_o(done_o[0]),
    .cmd_loop_break_o(brk_o[0]), .cmd_loop_iter_o(iter_o[0]), .ap_start(ap_start[0]),
    .ap_ready(ready[0]), .ap_done(done[0]), .ap_idle(ap_idle_in), .ap_return(ret[0]),
    .ap_idx(idx_o[0]), .ap_last(ap_last[0]), .dbg_status(dbg[0])
  );

  nestloop #(.MAX_OUTSTANDING(2)) u_max2 (
    .clk(clk), .rst(rst), .cmd_start(start[1]), .cmd_abort(abort[1]),
    .cmd_loop_init_i(init), .cmd_loop_len_i(len), .cmd_loop_inc_i(inc),
    .cmd_break_en_i(brk_en), .cmd_loop_idle_o(idle_o[1]), .cmd_loop_done_o(done_o[1]),
    .cmd_loop_break_o(brk_o[1]), .cmd_loop_iter_o(iter_o[1]), .ap_start(ap_start[1]),
    .ap_ready(ready[1]), .ap_done(done[1]), .ap_idle(ap_idle_in), .ap_return(ret[1]),
    .ap_idx(idx_o[1]), .ap_last(ap_last[1]), .dbg_status(dbg[1])
  );

  nestloop #(.ENABLE_PIPELINE(0)) u_seq (
    .clk(clk), .rst(rst), .cmd_start(start[2]), .cmd_abort(abort[2]),
    .cmd_loop_init_i(init), .cmd_loop_len_i(len), .cmd_loop_inc_i(inc),
    .cmd_break_en_i(brk_en), .cmd_loop_idle_o(idle_o[2]), .cmd_loop_done_o(done_o[2]),
    .cmd_loop_break_o(brk_o[2]), .cmd_loop_iter_o(iter_o[2]), .ap_start(ap_start[2]),
    .ap_ready(ready[2]), .ap_done(done[2]), .ap_idle(ap_idle_in), .ap_return(ret[2]),
    .ap_idx(idx_o[2]), .ap_last(ap_last[2]), .dbg_status(dbg[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] d0, input logic [31:0] d1);
    exp_q.push_back({d1, d0});
  endtask

  // driver + responder: start in window 0, each accepted call completes lat
  // windows later; ret carried from the ret_at-th ap_done onward.
  task automatic run_inst(input int u, input string tag, input int lat, input int ret_at,
                          input int accept_max, input int abort_at, input int exp_done,
                          input int exp_iter, input int exp_brk, input int exp_issued,
                          input int exp_infl);
    int issued = 0;
    int dones = 0;
    int infl = 0;
    int max_infl = 0;
    int done_at = -1;
    int due_q [$];
    logic got_iss, got_done;
    logic [63:0] e;
    for (int cyc = 0; cyc < 200 && done_at < 0; cyc++) begin
      start[u] = (cyc == 0);
      abort[u] = (cyc == abort_at);
      got_done = (due_q.size() > 0) && (due_q[0] == cyc);
      if (got_done) void'(due_q.pop_front());
      done[u]  = got_done;
      ret[u]   = got_done && (dones + 1 >= ret_at);
      ready[u] = (issued < accept_max) || (dones >= ret_at);
      if (done_o[u]) begin
        done_at = cyc;
        check({tag, "_iter"}, 64'(iter_o[u]), 64'(exp_iter));
        check({tag, "_brk"}, 64'(brk_o[u]), 64'(exp_brk));
      end
      got_iss = ap_start[u] && ready[u];
      if (got_iss) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_issue"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_idx%0d", tag, issued), 64'(idx_o[u]), e);
          check($sformatf("%s_last%0d", tag, issued), 64'(ap_last[u]), 64'(exp_q.size() == 0));
        end
        issued++;
        due_q.push_back(cyc + lat);
      end
      if (got_done) dones++;
      infl = infl + int'(got_iss) - int'(got_done);
      if (infl > max_infl) max_infl = infl;
      tick();
    end
    start[u] = 1'b0;
    abort[u] = 1'b0;
    done[u]  = 1'b0;
    ret[u]   = 1'b0;
    ready[u] = 1'b0;
    check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    check({tag, "_issued"}, 64'(issued), 64'(exp_issued));
    check({tag, "_max_inflight"}, 64'(max_infl), 64'(exp_infl));
    check({tag, "_idle_after"}, 64'(idle_o[u]), 64'd1);
    check({tag, "_done_pulse"}, 64'(done_o[u]), 64'd0);
    check({tag, "_brk_after"}, 64'(brk_o[u]), 64'd0);
    check({tag, "_iter_hold"}, 64'(iter_o[u]), 64'(exp_iter));
    exp_q.delete();
    tick();
  endtask

  task automatic cfg_basic();
    init = {32'd10, 32'd0};
    len  = {32'd2, 32'd3};
    inc  = {16'd5, 16'd1};
  endtask

  task automatic push_basic();
    push_pair(0, 10); push_pair(1, 10); push_pair(2, 10);
    push_pair(0, 15); push_pair(1, 15); push_pair(2, 15);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1;
    start = '0; abort = '0; ready = '0; done = '0; ret = '0;
    init = '0; len = '0; inc = '0; brk_en = 1'b0; ap_idle_in = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;

    // reset values
    check("rst_idle", 64'(idle_o[0]), 64'd1);
    check("rst_start", 64'(ap_start[0]), 64'd0);
    check("rst_idx", 64'(idx_o[0]), 64'd0);
    check("rst_last", 64'(ap_last[0]), 64'd0);
    check("rst_done", 64'(done_o[0]), 64'd0);
    check("rst_brk", 64'(brk_o[0]), 64'd0);
    check("rst_iter", 64'(iter_o[0]), 64'd0);
    for (int u = 0; u < 3; u++) check($sformatf("rst_dbg%0d", u), 64'(dbg[u]), 64'd0);
    tick();

    // 2-D walk, pipelined, ready held high
    cfg_basic();
    push_basic();
    run_inst(0, "walk", 3, 999, 99, -1, 10, 6, 0, 6, 3);

    // negative stride on dim 0
    init = {32'd7, 32'd100};
    len  = {32'd1, 32'd4};
    inc  = {16'd0, 16'hFFFE};
    push_pair(100, 7); push_pair(98, 7); push_pair(96, 7); push_pair(94, 7);
    run_inst(0, "neg", 2, 999, 99, -1, 7, 4, 0, 4, 2);

    // zero-length outer dimension
    init = {32'd10, 32'd0};
    len  = {32'd0, 32'd3};
    inc  = {16'd5, 16'd1};
    run_inst(0, "zero", 2, 999, 99, -1, 1, 0, 0, 0, 0);

    // break on the 2nd ap_done with 4 calls in flight
    cfg_basic();
    brk_en = 1'b1;
    push_basic();
    run_inst(0, "break", 5, 2, 4, -1, 10, 4, 1, 4, 4);
    brk_en = 1'b0;

    // abort while issuing
    cfg_basic();
    push_basic();
    run_inst(0, "abort", 4, 999, 99, 2, 7, 2, 1, 2, 2);

    // MAX_OUTSTANDING=2 with slow completions
    cfg_basic();
    push_basic();
    run_inst(1, "max2", 5, 999, 99, -1, 20, 6, 0, 6, 2);

    // one call in flight
    cfg_basic();
    push_basic();
    run_inst(2, "seq", 3, 999, 99, -1, 25, 6, 0, 6, 1);

    // reset in the middle of a run
    cfg_basic();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    ready[0] = 1'b1;
    tick(); tick();
    check("mid_busy", 64'(idle_o[0]), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready[0] = 1'b0;
    check("mid_idle", 64'(idle_o[0]), 64'd1);
    check("mid_start", 64'(ap_start[0]), 64'd0);
    check("mid_idx", 64'(idx_o[0]), 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_o[0]) pulses++;
      tick();
    end
    check("mid_no_done", 64'(pulses), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
